// File: rtl/forest_vote_sched.sv
// Sequencer for a one-vs-rest decision-tree forest: registers features, waits a settle window,
// tallies per-class votes one class per cycle and returns the argmax. Optional: FOREST_REJECT_EN.
module forest_vote_sched #(
  parameter int N_FEAT     = 51,
  parameter int N_CLASS    = 4,
  parameter int N_TREES    = 8,
  parameter int SETTLE_CYC = 2,
  parameter int MIN_VOTES  = 5,
  localparam int CLW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1,
  localparam int CW  = $clog2(N_TREES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_FEAT-1:0]          in_feat,
  output logic [N_FEAT-1:0]          feat_o,
  input  logic [N_CLASS*N_TREES-1:0] tree_hits,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [CLW-1:0]             res_class,
  output logic [CW-1:0]              res_votes,
  output logic                       res_reject,
  output logic                       busy
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  if (N_CLASS < 2 || N_TREES < 1 || SETTLE_CYC < 1 || MIN_VOTES < 0) begin : g_param_check
    $error("forest_vote_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, HOLD} state_e;

  state_e                            state_q;
  logic                              in_ready_q, busy_q, res_valid_q;
  logic [N_FEAT-1:0]                 feat_q;
  logic [SW-1:0]                     settle_q;
  logic [N_CLASS-1:0][N_TREES-1:0]   hits_q;
  logic [CLW-1:0]                    cls_q, best_cls_q, best_cls_d, res_class_q;
  logic [CW-1:0]                     best_cnt_q, best_cnt_d, cnt_d, res_votes_q;
  logic                              take_d;

  // Popcount of the class under evaluation and running argmax (strict > keeps lowest index on ties).
  always_comb begin
    cnt_d = '0;
    for (int unsigned t = 0; t < N_TREES; t++) begin
      cnt_d = cnt_d + CW'(hits_q[cls_q][t]);
    end
    take_d     = (cls_q == '0) || (cnt_d > best_cnt_q);
    best_cnt_d = take_d ? cnt_d : best_cnt_q;
    best_cls_d = take_d ? cls_q : best_cls_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      feat_q      <= '0;
      settle_q    <= '0;
      hits_q      <= '0;
      cls_q       <= '0;
      best_cls_q  <= '0;
      best_cnt_q  <= '0;
      res_class_q <= '0;
      res_votes_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            feat_q     <= in_feat;
            settle_q   <= SW'(SETTLE_CYC - 1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SETTLE;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_q == '0) begin
            hits_q  <= tree_hits;
            cls_q   <= '0;
            state_q <= COUNT;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        COUNT: begin
          best_cnt_q <= best_cnt_d;
          best_cls_q <= best_cls_d;
          if (cls_q == CLW'(N_CLASS - 1)) begin
            res_class_q <= best_cls_d;
            res_votes_q <= best_cnt_d;
            res_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            cls_q <= cls_q + 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FOREST_REJECT_EN
  localparam logic [CW-1:0] MIN_V = CW'(MIN_VOTES);
  logic res_reject_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_reject_q <= 1'b0;
    end else if (state_q == COUNT && cls_q == CLW'(N_CLASS - 1)) begin
      res_reject_q <= (best_cnt_d < MIN_V);
    end
  end

  assign res_reject = res_reject_q;
`else
  assign res_reject = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign feat_o    = feat_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_votes = res_votes_q;

endmodule

// File: tb/tb_forest_vote_sched.sv
// Self-checking bench for forest_vote_sched: directed cases plus randomized vectors
// scored against an argmax-of-popcounts reference model.
module tb_forest_vote_sched;

  localparam int NF  = 51;
  localparam int NC  = 4;
  localparam int NT  = 8;
  localparam int SC  = 2;
  localparam int MV  = 5;
  localparam int CLW = 2;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst_n, in_valid, in_ready, res_valid, res_ready, res_reject, busy;
  logic [NF-1:0]     in_feat, feat_o;
  logic [NC*NT-1:0]  tree_hits;
  logic [CLW-1:0]    res_class;
  logic [CW-1:0]     res_votes;

  int n_chk = 0;
  int n_err = 0;

  forest_vote_sched #(
    .N_FEAT(NF), .N_CLASS(NC), .N_TREES(NT), .SETTLE_CYC(SC), .MIN_VOTES(MV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .feat_o(feat_o), .tree_hits(tree_hits), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_votes(res_votes), .res_reject(res_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NF-1:0] rand_feat();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[NF-1:0];
  endfunction

  // Reference: per-class vote count, first class with the highest count wins.
  function automatic void model(input logic [NC*NT-1:0] h, output int cls, output int votes,
                                output bit rej);
    int v;
    cls = 0;
    votes = -1;
    for (int c = 0; c < NC; c++) begin
      v = $countones(h[c*NT +: NT]);
      if (v > votes) begin
        votes = v;
        cls = c;
      end
    end
`ifdef FOREST_REJECT_EN
    rej = (votes < MV);
`else
    rej = 1'b0;
`endif
  endfunction

  function automatic logic [NC*NT-1:0] rand_hits();
    logic [NC*NT-1:0] h;
    int dens;
    for (int c = 0; c < NC; c++) begin
      dens = $urandom_range(0, 100);
      for (int t = 0; t < NT; t++) h[c*NT+t] = ($urandom_range(0, 99) < dens);
    end
    return h;
  endfunction

  // Accept one vector, present the real hits only at the sampling edge, then check the result.
  // mid_rst=1 pulses reset in the second COUNT cycle instead of collecting the result.
  task automatic run_vec(input logic [NF-1:0] f, input logic [NC*NT-1:0] h, input int hold,
                         input bit mid_rst);
    int cls, votes, n;
    bit rej;
    model(h, cls, votes, rej);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid  = 1'b1;
    in_feat   = f;
    tree_hits = ~h;
    @(posedge clk);
    for (int k = 1; k <= SC; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("feat_o", feat_o, f);
        chk("busy_hi", busy, 1);
        chk("in_ready_lo", in_ready, 0);
      end
      in_feat   = rand_feat();
      tree_hits = (k == SC) ? h : ~h;
      @(posedge clk);
    end
    if (mid_rst) begin
      @(negedge clk);
      tree_hits = ~h;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_feat_o", feat_o, 0);
      chk("rst_votes", res_votes, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready_rise", in_ready, 1);
      chk("rst_no_result", res_valid, 0);
      return;
    end
    n = SC;
    @(negedge clk);
    tree_hits = ~h;
    while (!res_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", n, SC + NC);
    for (int i = 0; i <= hold; i++) begin
      chk("res_valid", res_valid, 1);
      chk("res_class", res_class, cls);
      chk("res_votes", res_votes, votes);
      chk("res_reject", res_reject, rej);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_feat_o", feat_o, f);
      in_feat = rand_feat();
      if (i < hold) @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    in_valid  = 1'b0;
    chk("done_res_valid", res_valid, 0);
    chk("done_in_ready", in_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_class_kept", res_class, cls);
    chk("done_votes_kept", res_votes, votes);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_feat   = rand_feat();
    res_ready = 1'b0;
    tree_hits = '0;
    repeat (3) @(negedge clk);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_feat_o", feat_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_class", res_class, 0);
    chk("reset_reject", res_reject, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_no_accept", busy, 0);
    chk("release_feat_o", feat_o, 0);
    in_valid = 1'b0;

    run_vec(51'h1, {8'h03, 8'hFF, 8'h03, 8'h03}, 0, 1'b0);
    run_vec(rand_feat(), {8'hF8, 8'h03, 8'h1F, 8'h03}, 10, 1'b0);
    run_vec(rand_feat(), '0, 1, 1'b0);
    run_vec(rand_feat(), {8'h0F, 8'h07, 8'h03, 8'h01}, 0, 1'b0);
    run_vec(rand_feat(), {8'h0F, 8'h1F, 8'h03, 8'h01}, 0, 1'b0);
    run_vec(rand_feat(), {8'h00, 8'hFF, 8'h00, 8'h01}, 0, 1'b1);
    run_vec(rand_feat(), {8'h00, 8'h00, 8'h00, 8'hFF}, 2, 1'b0);
    run_vec(rand_feat(), {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, 1'b0);

    for (int v = 0; v < 40; v++) begin
      run_vec(rand_feat(), rand_hits(), $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/forest_vote_sched.md
Name: forest_vote_sched

Overview:
- Sequencing controller for a bank of synthesized one-vs-rest decision-tree classifiers: N_CLASS classes × N_TREES combinational trees, each taking the shared feature vector and giving a 1-bit hit.
- Accepts feature vectors over valid/ready and drives them, registered, to the tree bank.
- Waits a fixed settle window (multicycle path through deep mux trees), samples all hits, tallies votes one class per cycle, and returns the argmax class over valid/ready.

Parameters:
- N_FEAT, 51, feature vector width.
- N_CLASS, 4, number of classes (≥2).
- N_TREES, 8, trees per class (≥1).
- SETTLE_CYC, 2, cycles feat_o is held before hits are sampled (≥1).
- MIN_VOTES, 5, reject threshold; used only with FOREST_REJECT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  controller can accept
- in_feat  in  N_FEAT  feature vector
- feat_o  out  N_FEAT  registered features to tree bank
- tree_hits  in  N_CLASS*N_TREES  tree outputs; bit c*N_TREES+t = tree t of class c
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_class  out  CLW=max(1,$clog2(N_CLASS))  winning class
- res_votes  out  CW=$clog2(N_TREES+1)  winning vote count
- res_reject  out  1  low-confidence flag
- busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; feat_o=0; res_valid=0; res_class=0; res_votes=0; res_reject=0; in_ready=0; busy=0.
- in_ready is registered: it rises on the first clk edge after rst_n releases.
- Thereafter in_ready=1 exactly while in IDLE.
- IDLE:
  - Accept on in_valid&&in_ready: feat_o<=in_feat, settle counter<=SETTLE_CYC-1, in_ready<=0, go SETTLE.
  - No accept: feat_o keeps its last value.
- SETTLE:
  - Counter decrements each cycle.
  - In the cycle the counter is 0: hits_q<=tree_hits, class index<=0, go COUNT.
  - So feat_o is stable for exactly SETTLE_CYC cycles before sampling.
- COUNT: one class c per cycle.
  - cnt=popcount(hits_q[c*N_TREES +: N_TREES]).
  - If c==0 or cnt>best_cnt: best_cnt<=cnt, best_cls<=c.
  - Strict > means ties resolve to the lowest index.
  - After c==N_CLASS-1: res_class/res_votes/res_reject<=final best, res_valid<=1, go HOLD.
- HOLD:
  - res_* are held stable while res_valid=1 && !res_ready.
  - On res_ready: res_valid<=0, in_ready<=1, go IDLE. Result fields keep their last values.
- Latency: with accept at edge E0, res_valid is high after edge E0+SETTLE_CYC+N_CLASS. Defaults give 6 cycles.
- Throughput: one vector per SETTLE_CYC+N_CLASS+2 cycles minimum; no overlap.
- in_valid is ignored outside IDLE. tree_hits is ignored except at the sampling edge.
- All-zero hits: res_class=0, res_votes=0.
- Vote width: CW bits hold N_TREES exactly; no saturation is needed.
- Reset mid-operation (any state): immediate return to reset values; the in-flight vector is discarded and no result is produced.
- busy=1 in SETTLE, COUNT, HOLD.

Optional Feature:
- FOREST_REJECT_EN defined: res_reject is set with the result when best_cnt < MIN_VOTES.
- Not defined: res_reject is constant 0 and no comparator is synthesized.
- Port list is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → res_valid=0, in_ready=0, feat_o=0. Release → in_ready=1 one edge later; no spurious accept.
- Single classify: in_feat=51'h1, class2 hits=8'hFF, others 8'h03 → feat_o=51'h1, res_class=2, res_votes=8, res_valid high 6 cycles after accept.
- Tie: class1=8'h1F, class3=8'hF8, class0=class2=8'h03 → res_class=1, res_votes=5.
- Backpressure: res_ready=0 for 10 cycles with in_valid=1 and changing in_feat → res_* stable, in_ready=0, feat_o unchanged. res_ready=1 → IDLE next edge, then the new vector is accepted.
- Reset mid-COUNT: pulse rst_n low during 2nd COUNT cycle → outputs zero at once. Next vector (class0 8'hFF) → res_class=0, votes=8.
- Reject, macro on, MIN_VOTES=5: max class count 4 → res_reject=1; with 5 → 0. Macro off: same stimulus → always 0.
